// File: rtl/user_obi_sram_resp.sv
// Memory-side responder for the Ibex req/gnt/rvalid bus: word-addressed flop SRAM
// with fixed read latency, bounded outstanding transactions and bus-error responses.
module user_obi_sram_resp #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 1,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(MAX_OUTST + 1);
    localparam logic [31:0] SPAN    = 32'(4 * DEPTH);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

    logic [31:0]   offset;
    logic          legal;
    logic          accept;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;

    logic [CW-1:0] outst_reg;
    logic [CW-1:0] outst_next;
    logic [CW-1:0] outst;

    logic          stage0_valid;
    logic          stage0_err;
    logic [31:0]   stage0_data;

    logic          valid_reg [LATENCY];
    logic          err_reg   [LATENCY];
    logic [31:0]   data_reg  [LATENCY];

    // Offset comparison avoids overflow when BASE_ADDR + 4*DEPTH wraps past 2^32.
    assign offset = addr_i - BASE_ADDR;
    assign legal  = (addr_i[1:0] == 2'b00) && (addr_i >= BASE_ADDR) && (offset < SPAN);
    assign idx    = offset[AW+1:2];

    // A response leaving the pipeline this cycle frees its slot for an immediate grant.
    assign outst      = outst_reg - CW'(rvalid_o);
    assign gnt_o      = req_i & ~rst_i & (outst < MAX_CNT);
    assign accept     = req_i & gnt_o;
    assign outst_next = outst + CW'(accept);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outst_reg <= '0;
        end else begin
            outst_reg <= outst_next;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_lane [DEPTH];

        always_ff @(posedge clk_i) begin
            if (accept && we_i && legal && be_i[gi]) begin
                mem_lane[idx] <= wdata_i[8*gi +: 8];
            end
        end

        assign rd_word[8*gi +: 8] = mem_lane[idx];
    end

    // Reads snapshot the word at accept, so later writes cannot disturb them.
    assign stage0_valid = accept;
    assign stage0_err   = accept & ~legal;
    assign stage0_data  = (accept && legal && !we_i) ? rd_word : 32'h0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_reg[i] <= 1'b0;
                err_reg[i]   <= 1'b0;
                data_reg[i]  <= 32'h0;
            end
        end else begin
            valid_reg[0] <= stage0_valid;
            err_reg[0]   <= stage0_err;
            data_reg[0]  <= stage0_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                err_reg[i]   <= err_reg[i-1];
                data_reg[i]  <= data_reg[i-1];
            end
        end
    end

    assign rvalid_o = valid_reg[LATENCY-1];
    assign err_o    = valid_reg[LATENCY-1] & err_reg[LATENCY-1];
    assign rdata_o  = valid_reg[LATENCY-1] ? data_reg[LATENCY-1] : 32'h0;

endmodule

// File: tb/tb_user_obi_sram_resp.sv
// Bench for user_obi_sram_resp: three parameterisations driven by directed and random
// requests, every response checked against a transaction-level memory/queue model.
module tb_user_obi_sram_resp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req   [3];
    logic [31:0] addr  [3];
    logic        we    [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic        gnt   [3];
    logic        rvalid[3];
    logic [31:0] rdata [3];
    logic        err   [3];

    user_obi_sram_resp #(.BASE_ADDR(32'h0000_0000), .DEPTH(256), .LATENCY(1), .MAX_OUTST(2)) u0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

    user_obi_sram_resp #(.BASE_ADDR(32'h0000_1000), .DEPTH(64), .LATENCY(3), .MAX_OUTST(2)) u1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

    user_obi_sram_resp #(.BASE_ADDR(32'h8000_0000), .DEPTH(16), .LATENCY(4), .MAX_OUTST(2)) u2 (
        .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
        .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
        bit          known;
    } resp_t;

    resp_t       q     [3][$];
    logic [31:0] mm    [3][256];
    logic [3:0]  kn    [3][256];
    logic [31:0] log_d [3][$];
    bit          log_e [3][$];
    int          rv_cnt  [3];
    int          obs_out [3];
    bit          acc_last[3];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] p_base(int k);
        case (k)
            0:       return 32'h0000_0000;
            1:       return 32'h0000_1000;
            default: return 32'h8000_0000;
        endcase
    endfunction

    function automatic int p_depth(int k);
        case (k)
            0:       return 256;
            1:       return 64;
            default: return 16;
        endcase
    endfunction

    function automatic int p_lat(int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int p_max(int k);
        return (k >= 0) ? 2 : 2;
    endfunction

    function automatic int win(int k);
        return (p_depth(k) < 32) ? p_depth(k) : 32;
    endfunction

    function automatic bit legal(int k, logic [31:0] a);
        logic [31:0] off;
        off = a - p_base(k);
        return (a[1:0] == 2'b00) && (a >= p_base(k)) && (off < 32'(4 * p_depth(k)));
    endfunction

    function automatic logic [31:0] last_d(int k);
        if (log_d[k].size() == 0) return 32'hFFFF_FFFF;
        return log_d[k][log_d[k].size() - 1];
    endfunction

    function automatic bit last_e(int k);
        if (log_e[k].size() == 0) return 1'b0;
        return log_e[k][log_e[k].size() - 1];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input bit w,
                           input logic [3:0] b, input logic [31:0] d);
        req[k]   = 1'b1;
        addr[k]  = a;
        we[k]    = w;
        be[k]    = b;
        wdata[k] = d;
    endtask

    // One bus cycle: check all three responders at the falling edge, update the model, advance.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bit    due_now;
            int    pend;
            bit    acc;
            resp_t e;
            resp_t r;
            int    wi;
            bit    ok;
            acc_last[k] = 1'b0;
            if (rst) begin
                chk("reset_outputs", 64'({gnt[k], rvalid[k], err[k], rdata[k]}), 64'(0));
                q[k].delete();
                obs_out[k] = 0;
            end else begin
                due_now = (q[k].size() > 0) && (q[k][0].due == cyc);
                pend    = q[k].size() - (due_now ? 1 : 0);
                chk("gnt", 64'(gnt[k]), 64'(req[k] && (pend < p_max(k))));
                chk("rvalid", 64'(rvalid[k]), 64'(due_now));
                if (due_now) begin
                    e = q[k].pop_front();
                    chk("err", 64'(err[k]), 64'(e.err));
                    if (e.known) chk("rdata", 64'(rdata[k]), 64'(e.data));
                end else begin
                    chk("rdata_idle", 64'(rdata[k]), 64'(0));
                end
                if (rvalid[k]) begin
                    rv_cnt[k]++;
                    log_d[k].push_back(rdata[k]);
                    log_e[k].push_back(err[k]);
                    $display("inst%0d cyc %0d response err=%0b rdata=%08h", k, cyc, err[k], rdata[k]);
                end
                acc = req[k] && gnt[k];
                obs_out[k] += int'(acc) - int'(rvalid[k]);
                chk("outst_bound", 64'((obs_out[k] >= 0) && (obs_out[k] <= p_max(k))), 64'(1));
                if (acc) begin
                    ok      = legal(k, addr[k]);
                    wi      = int'((addr[k] - p_base(k)) >> 2);
                    r.due   = cyc + p_lat(k);
                    r.err   = !ok;
                    r.data  = 32'h0;
                    r.known = 1'b1;
                    if (ok && we[k]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be[k][b]) begin
                                mm[k][wi][8*b +: 8] = wdata[k][8*b +: 8];
                                kn[k][wi][b]        = 1'b1;
                            end
                        end
                    end
                    if (ok && !we[k]) begin
                        r.data  = mm[k][wi];
                        r.known = (kn[k][wi] == 4'hF);
                    end
                    q[k].push_back(r);
                end
                acc_last[k] = acc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic txn(input int k, input logic [31:0] a, input bit w,
                       input logic [3:0] b, input logic [31:0] d);
        bit granted;
        granted = 1'b0;
        set_req(k, a, w, b, d);
        for (int n = 0; n < 20 && !granted; n++) begin
            step();
            granted = acc_last[k];
        end
        req[k] = 1'b0;
        chk("grant_timeout", 64'(granted), 64'(1));
    endtask

    task automatic drain();
        repeat (8) step();
        for (int k = 0; k < 3; k++) chk("drained", 64'(q[k].size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [5:0]  pat;
        int          n_gr;
        int          base_cnt;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; addr[k] = 32'h0; we[k] = 1'b0; be[k] = 4'h0; wdata[k] = 32'h0;
            rv_cnt[k] = 0; obs_out[k] = 0; acc_last[k] = 1'b0;
            for (int w = 0; w < 256; w++) kn[k][w] = 4'h0;
        end
        @(posedge clk);
        #1;
        step();
        set_req(0, 32'h10, 1'b0, 4'hF, 32'h0);
        step();
        rst = 1'b0;
        req[0] = 1'b0;

        // Write/read and byte enables on the default instance
        txn(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
        drain();
        txn(0, 32'h10, 1'b0, 4'hF, 32'h0);
        drain();
        chk("rd_deadbeef", 64'(last_d(0)), 64'(32'hDEADBEEF));
        txn(0, 32'h10, 1'b1, 4'b0101, 32'h11223344);
        txn(0, 32'h10, 1'b0, 4'h0, 32'h0);
        drain();
        chk("rd_byte_en", 64'(last_d(0)), 64'(32'hDE22BE44));

        // Error responses
        txn(0, 32'h0, 1'b1, 4'hF, 32'h0BADF00D);
        drain();
        txn(0, 32'h402, 1'b0, 4'hF, 32'h0);
        drain();
        chk("err_misaligned", 64'({last_e(0), last_d(0)}), 64'({1'b1, 32'h0}));
        txn(0, 32'h400, 1'b0, 4'hF, 32'h0);
        drain();
        chk("err_above", 64'({last_e(0), last_d(0)}), 64'({1'b1, 32'h0}));
        txn(0, 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0);
        drain();
        chk("err_below", 64'({last_e(0), last_d(0)}), 64'({1'b1, 32'h0}));
        txn(0, 32'h400, 1'b1, 4'hF, 32'h5555_5555);
        drain();
        chk("err_write", 64'({last_e(0), last_d(0)}), 64'({1'b1, 32'h0}));
        txn(0, 32'h0, 1'b0, 4'hF, 32'h0);
        drain();
        chk("mem_kept_w0", 64'(last_d(0)), 64'(32'h0BADF00D));
        txn(0, 32'h10, 1'b0, 4'hF, 32'h0);
        drain();
        chk("mem_kept_w4", 64'(last_d(0)), 64'(32'hDE22BE44));

        // Outstanding limit: LATENCY=3, MAX_OUTST=2, request held for six reads
        for (int i = 0; i < 6; i++) txn(1, 32'h1000 + 32'(4 * i), 1'b1, 4'hF, 32'h1000 + 32'(i * 32'h111));
        drain();
        rv_cnt[1] = 0;
        n_gr = 0;
        pat  = 6'h0;
        set_req(1, 32'h1000, 1'b0, 4'hF, 32'h0);
        for (int c = 0; c < 30 && n_gr < 6; c++) begin
            step();
            if (c < 6) pat = {pat[4:0], acc_last[1]};
            if (acc_last[1]) begin
                n_gr++;
                addr[1] = 32'h1000 + 32'(4 * n_gr);
            end
        end
        req[1] = 1'b0;
        chk("outst_grants", 64'(n_gr), 64'(6));
        drain();
        chk("gnt_pattern", 64'(pat), 64'(6'b110110));
        chk("rvalid_total", 64'(rv_cnt[1]), 64'(6));

        // Read snapshot: LATENCY=4 read followed by a write to the same word
        txn(2, 32'h8000_0014, 1'b1, 4'hF, 32'hA5A5A5A5);
        drain();
        log_d[2].delete();
        set_req(2, 32'h8000_0014, 1'b0, 4'hF, 32'h0);
        step();
        chk("snap_rd_gnt", 64'(acc_last[2]), 64'(1));
        set_req(2, 32'h8000_0014, 1'b1, 4'hF, 32'h0);
        step();
        chk("snap_wr_gnt", 64'(acc_last[2]), 64'(1));
        req[2] = 1'b0;
        txn(2, 32'h8000_0014, 1'b0, 4'hF, 32'h0);
        drain();
        chk("snap_count", 64'(log_d[2].size()), 64'(3));
        chk("snap_old", 64'(log_d[2][0]), 64'(32'hA5A5A5A5));
        chk("snap_new", 64'(log_d[2][2]), 64'(32'h0));

        // Reset with two reads in flight
        set_req(1, 32'h1000, 1'b0, 4'hF, 32'h0);
        step();
        chk("mid_gnt0", 64'(acc_last[1]), 64'(1));
        addr[1] = 32'h1004;
        step();
        chk("mid_gnt1", 64'(acc_last[1]), 64'(1));
        base_cnt = rv_cnt[1];
        rst = 1'b1;
        set_req(1, 32'h1008, 1'b0, 4'hF, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("post_reset_grant", 64'(acc_last[1]), 64'(1));
        req[1] = 1'b0;
        drain();
        chk("rvalids_after_reset", 64'(rv_cnt[1] - base_cnt), 64'(1));
        chk("post_reset_data", 64'(last_d(1)), 64'(32'h1222));

        // Randomised traffic on all three instances
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < win(k); w++) txn(k, p_base(k) + 32'(4 * w), 1'b1, 4'hF, $urandom);
        end
        drain();
        for (int it = 0; it < 300; it++) begin
            for (int k = 0; k < 3; k++) begin
                if (!req[k] || acc_last[k]) begin
                    if ($urandom_range(3) == 0) begin
                        req[k] = 1'b0;
                    end else begin
                        int w;
                        w = int'($urandom_range(win(k) - 1));
                        case ($urandom_range(7))
                            0:       a = p_base(k) + 32'(4 * w) + 32'($urandom_range(3, 1));
                            1:       a = p_base(k) + 32'(4 * p_depth(k)) + 32'(4 * $urandom_range(3));
                            2:       a = p_base(k) - 32'd4;
                            default: a = p_base(k) + 32'(4 * w);
                        endcase
                        set_req(k, a, 1'($urandom_range(1)), 4'($urandom), $urandom);
                    end
                end
            end
            step();
        end
        for (int k = 0; k < 3; k++) req[k] = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/user_obi_sram_resp.md
# user_obi_sram_resp

Memory-side responder for the Ibex instruction/data bus (req/gnt/rvalid protocol) inside a user core slot. It is the other end of the core's `data_*` / `instr_*` ports, which are currently tied off. The block is a word-addressed flop-based SRAM with a fixed, parameterised read latency and a bounded number of outstanding transactions. Out-of-range or misaligned accesses get a bus-error response.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- `DEPTH`, 256: number of 32-bit words; power of two, 16..1024.
- `LATENCY`, 1: cycles from grant to `rvalid_o`; legal range 1..4.
- `MAX_OUTST`, 2: maximum accepted-but-unanswered transactions; legal range 1..LATENCY+1.

Ports:
- `clk_i` in 1: clock; all state on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_i` in 1: request valid from the core.
- `gnt_o` out 1: request accepted this cycle.
- `addr_i` in 32: byte address.
- `we_i` in 1: 1 means write, 0 means read.
- `be_i` in 4: byte enables; bit n covers `wdata_i[8n+7:8n]`.
- `wdata_i` in 32: write data.
- `rvalid_o` out 1: response valid, one cycle per accepted request.
- `rdata_o` out 32: read data; 0 for writes, errors, and when `rvalid_o`=0.
- `err_o` out 1: error flag; qualified by `rvalid_o`.

## Operation
- **Grant.** `gnt_o = req_i & ~rst_i & (outst < MAX_OUTST)`, combinational.
  - Accept means `req_i & gnt_o` in the same cycle.
  - Address, we, be and wdata are sampled only on accept.
- **Legal access.** `addr_i[1:0]==0` and `BASE_ADDR <= addr_i < BASE_ADDR + 4*DEPTH`.
  - Word index = `(addr_i - BASE_ADDR) >> 2`.
- **Write, legal.** Bytes with `be_i[n]=1` are updated at the accept edge; other bytes are unchanged.
  - `be_i=0` is a legal no-op write.
  - Response: `rdata_o`=0, `err_o`=0.
- **Read, legal.** The full word is captured at the accept edge, regardless of `be_i`.
  - A write accepted on a later cycle never alters an already-accepted read.
- **Illegal access.** No memory update. Response: `rdata_o`=0, `err_o`=1.
- **Response pipeline.** A LATENCY-stage shift register of {valid, err, data}.
  - Stage 0 is loaded on accept; the last stage drives the outputs.
  - Responses are strictly in order. There is no backpressure on the response channel.
- **Outstanding counter `outst`**, width clog2(MAX_OUTST+1).
  - +1 on accept, −1 when `rvalid_o`=1.
  - Simultaneous accept and retire: counter unchanged.
  - The counter never exceeds MAX_OUTST and never underflows; verification asserts both.
- **Memory reset.** Memory contents are not reset; the value is undefined until first written.
  - The bench must write before it checks read data.

## Timing
- Reset values: `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `outst`=0, all pipeline valids 0.
- Reset asserted mid-transaction: all pending responses are dropped and no `rvalid_o` is issued for them.
  - A write accepted on the edge where reset asserts may or may not land; it is unspecified.
- Latency: request accepted at edge T produces `rvalid_o`=1 during the cycle after edge T+LATENCY−1.
  - With LATENCY=1, `rvalid_o` is high the cycle after the grant cycle.
- Throughput: with MAX_OUTST ≥ LATENCY, one accept per cycle is sustained.
  - Otherwise `gnt_o` drops when `outst==MAX_OUTST` and reasserts in the cycle `rvalid_o` retires an entry, since the retire frees a slot combinationally through `outst`.
- Back-to-back write then read of the same word, accepted on consecutive cycles: the read returns the new data.
- Write and read of the same word accepted in the same cycle cannot occur (single port).
- `req_i` held with no grant: the core holds its address stable. The block needs no internal stall state for this.

## Test plan
- **Write/read, defaults.** Write 32'hDEADBEEF, be=4'hF, to BASE+0x10; then read BASE+0x10.
  - Required: `rvalid_o` one cycle after each grant, read `rdata_o`=32'hDEADBEEF, `err_o`=0.
- **Byte enables.** After the above, write 32'h11223344 with be=4'b0101; read back.
  - Required: 32'hDE22BE44.
- **Errors.** Read BASE+0x402 (misaligned), read BASE+4*DEPTH, read BASE−4, write BASE+4*DEPTH.
  - Required: each gets `rvalid_o`=1, `err_o`=1, `rdata_o`=0; memory is unchanged afterwards.
- **Outstanding limit.** LATENCY=3, MAX_OUTST=2, `req_i` held high for 6 reads.
  - Required: `gnt_o` pattern 1,1,0,1,1,0 with responses in order.
  - Required: `outst` never exceeds 2, and exactly 6 rvalids in total.
- **Read snapshot.** LATENCY=4: read word 5 (holding 32'hA5A5A5A5), then next cycle write 32'h0 to word 5.
  - Required: read returns 32'hA5A5A5A5; a subsequent read returns 0.
- **Reset mid-flight.** Assert `rst_i` for one cycle while 2 reads are pending (LATENCY=3).
  - Required: no `rvalid_o` for them, all outputs 0 during reset, and the next request is granted immediately after reset release.
